// File: rtl/uart_pkg.sv
// Shared UART types: the data byte and the transmit-buffer handshake states.
package uart_pkg;
  typedef logic [7:0] uart_data_t;
  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK} tx_buf_state_e;
endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO with occupancy count; flush wins over any same-cycle write or read.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  uart_data_t               wr_data_i,
  input  logic                     rd_en_i,
  input  logic                     flush_i,
  output uart_data_t               rd_data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  uart_data_t        mem [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              wr_ok, rd_ok;

  assign full_o    = (level_q == LW'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign rd_data_o = mem[rptr_q];

  assign wr_ok = wr_en_i & ~full_o & ~flush_i;
  assign rd_ok = rd_en_i & ~empty_o & ~flush_i;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      // Pointers are exactly AW bits wide, so +1 wraps DEPTH-1 -> 0.
      if (wr_ok) wptr_d = wptr_q + 1'b1;
      if (rd_ok) rptr_d = rptr_q + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem[wptr_q] <= wr_data_i;
  end
endmodule

// File: rtl/uart_tx_buffer.sv
// Transmit FIFO feeding UART_tx: pops one byte at a time through a send/ready
// handshake and reports fill level, watermark and sticky overflow.
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int THRESH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_en_i,
  input  uart_data_t             wr_data_i,
  input  logic                   flush_i,
  input  logic                   tx_en_i,
  input  logic                   ovf_clr_i,
  input  logic                   tx_data_ready_i,
  output uart_data_t             tx_data_o,
  output logic                   send_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   tx_low_o,
  output logic                   overflow_o
);
  localparam int LW = $clog2(DEPTH) + 1;

  tx_buf_state_e state_q, state_d;
  uart_data_t    tx_data_q, tx_data_d, head;
  logic          send_q, ovf_q, ovf_d, pop;

  uart_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (wr_en_i),
    .wr_data_i (wr_data_i),
    .rd_en_i   (pop),
    .flush_i   (flush_i),
    .rd_data_o (head),
    .level_o   (level_o),
    .full_o    (full_o),
    .empty_o   (empty_o)
  );

  // A pop is suppressed while flushing so a cleared byte is never launched.
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_en_i && !empty_o && tx_data_ready_i && !flush_i) begin
          pop       = 1'b1;
          tx_data_d = head;
          state_d   = SEND;
        end
      end
      SEND:     state_d = WAIT_ACK;
      WAIT_ACK: if (!tx_data_ready_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Dropped write beats a same-cycle clear; a flushed write is not a drop.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_en_i && full_o && !flush_i) ovf_d = 1'b1;
    else if (ovf_clr_i)                ovf_d = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      tx_data_q <= '0;
      send_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      send_q    <= (state_d == SEND);
      ovf_q     <= ovf_d;
    end
  end

  assign tx_data_o  = tx_data_q;
  assign send_o     = send_q;
  assign overflow_o = ovf_q;
  assign tx_low_o   = (level_o <= LW'(THRESH));
endmodule

// File: tb/tb_uart_tx_buffer.sv
// Self-checking bench for uart_tx_buffer: vector table, directed corner cases,
// and randomized traffic against a queue-based reference model.
module tb_uart_tx_buffer;
  localparam int DEPTH  = 16;
  localparam int THRESH = 4;

  logic       clk_i = 1'b0;
  logic       rst_i, wr_en_i, flush_i, tx_en_i, ovf_clr_i, tx_data_ready_i;
  logic [7:0] wr_data_i, tx_data_o;
  logic       send_o, full_o, empty_o, tx_low_o, overflow_o;
  logic [4:0] level_o;

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  byte unsigned m_q[$];
  int           m_ph;     // 0 nothing in flight, 1 pulse due, 2 awaiting UART accept
  logic [7:0]   m_txd;
  bit           m_ovf;

  uart_tx_buffer #(.DEPTH(DEPTH), .THRESH(THRESH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .wr_en_i(wr_en_i), .wr_data_i(wr_data_i),
    .flush_i(flush_i), .tx_en_i(tx_en_i), .ovf_clr_i(ovf_clr_i),
    .tx_data_ready_i(tx_data_ready_i), .tx_data_o(tx_data_o), .send_o(send_o),
    .full_o(full_o), .empty_o(empty_o), .level_o(level_o), .tx_low_o(tx_low_o),
    .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit w, input logic [7:0] d, input bit f,
                            input bit te, input bit oc, input bit rdy);
    bit full_pre, can_pop, dropped;
    if (r) begin
      m_q.delete(); m_ph = 0; m_txd = 8'h00; m_ovf = 1'b0;
      return;
    end
    full_pre = (m_q.size() == DEPTH);
    can_pop  = (m_ph == 0) && te && (m_q.size() > 0) && rdy && !f;
    dropped  = w && !f && full_pre;
    if (m_ph == 0)      m_ph = can_pop ? 1 : 0;
    else if (m_ph == 1) m_ph = 2;
    else                m_ph = rdy ? 2 : 0;
    if (can_pop) m_txd = m_q.pop_front();
    if (f) m_q.delete();
    else if (w && !full_pre) m_q.push_back(d);
    if (dropped) m_ovf = 1'b1;
    else if (oc) m_ovf = 1'b0;
  endtask

  // One clock: inputs sampled at the edge feed the model, outputs compared 1ns later.
  task automatic tick();
    bit r = rst_i, w = wr_en_i, f = flush_i, te = tx_en_i, oc = ovf_clr_i, rdy = tx_data_ready_i;
    logic [7:0] d = wr_data_i;
    logic [31:0] act, exp;
    int sz;
    @(posedge clk_i); #1;
    model_step(r, w, d, f, te, oc, rdy);
    sz  = m_q.size();
    exp = {14'd0, (m_ph == 1), (sz == DEPTH), (sz == 0), (sz <= THRESH), m_ovf, 5'(sz), m_txd};
    act = {14'd0, send_o, full_o, empty_o, tx_low_o, overflow_o, level_o, tx_data_o};
    check("model", act, exp);
  endtask

  task automatic idle_inputs();
    wr_en_i = 0; wr_data_i = 8'h00; flush_i = 0; ovf_clr_i = 0;
  endtask

  typedef struct {
    bit wr; logic [7:0] data; bit fl; bit rdy;
    bit e_send; int e_lvl; bit e_empty; logic [7:0] e_txd;
  } vec_t;
  vec_t vt[9];

  initial begin
    int busy, nsent, prev_lvl;
    logic [7:0] last;
    bit low_edge;

    rst_i = 1; tx_en_i = 1; tx_data_ready_i = 1; idle_inputs();
    m_q.delete(); m_ph = 0; m_txd = 0; m_ovf = 0;
    #1;
    check("rst_empty", 32'(empty_o), 1);
    check("rst_full", 32'(full_o), 0);
    check("rst_txlow", 32'(tx_low_o), 1);
    check("rst_level", 32'(level_o), 0);
    check("rst_send", 32'(send_o), 0);
    check("rst_ovf", 32'(overflow_o), 0);
    check("rst_txd", 32'(tx_data_o), 0);
    tick(); tick();
    rst_i = 0;

    // vector table: latency, handshake and flush-over-write
    vt[0] = '{1, 8'hA5, 0, 1, 0, 1, 0, 8'h00};
    vt[1] = '{0, 8'h00, 0, 1, 1, 0, 1, 8'hA5};
    vt[2] = '{0, 8'h00, 0, 0, 0, 0, 1, 8'hA5};
    vt[3] = '{0, 8'h00, 0, 0, 0, 0, 1, 8'hA5};
    vt[4] = '{1, 8'h3C, 1, 0, 0, 0, 1, 8'hA5};
    vt[5] = '{1, 8'h11, 0, 0, 0, 1, 0, 8'hA5};
    vt[6] = '{0, 8'h00, 0, 1, 1, 0, 1, 8'h11};
    vt[7] = '{0, 8'h00, 0, 1, 0, 0, 1, 8'h11};
    vt[8] = '{0, 8'h00, 0, 0, 0, 0, 1, 8'h11};
    for (int i = 0; i < 9; i++) begin
      wr_en_i = vt[i].wr; wr_data_i = vt[i].data; flush_i = vt[i].fl; tx_data_ready_i = vt[i].rdy;
      tick();
      check($sformatf("vec%0d_send", i), 32'(send_o), 32'(vt[i].e_send));
      check($sformatf("vec%0d_level", i), 32'(level_o), 32'(vt[i].e_lvl));
      check($sformatf("vec%0d_empty", i), 32'(empty_o), 32'(vt[i].e_empty));
      check($sformatf("vec%0d_txd", i), 32'(tx_data_o), 32'(vt[i].e_txd));
    end
    idle_inputs();

    // fill to full, overflow, clear priority
    tx_data_ready_i = 0;
    for (int i = 0; i < 16; i++) begin
      wr_en_i = 1; wr_data_i = 8'(i); tick();
    end
    check("fill_full", 32'(full_o), 1);
    check("fill_level", 32'(level_o), 16);
    check("fill_txlow", 32'(tx_low_o), 0);
    wr_data_i = 8'hEE; tick();
    check("ovf_set", 32'(overflow_o), 1);
    check("ovf_level", 32'(level_o), 16);
    ovf_clr_i = 1; tick();
    check("ovf_set_wins", 32'(overflow_o), 1);
    wr_en_i = 0; tick();
    check("ovf_clr", 32'(overflow_o), 0);
    idle_inputs();

    // drain with a UART that stays busy 10 cycles per byte
    busy = 0; nsent = 0; low_edge = 0; prev_lvl = level_o; last = 8'h00;
    for (int c = 0; c < 400 && nsent < 16; c++) begin
      tx_data_ready_i = (busy == 0);
      tick();
      if (busy > 0) busy--;
      if (send_o) begin
        check("drain_order", 32'(tx_data_o), 32'(nsent));
        nsent++; last = tx_data_o; busy = 10;
      end else if (nsent > 0) begin
        check("drain_stable", 32'(tx_data_o), 32'(last));
      end
      if (prev_lvl == 5 && level_o == 4) begin
        low_edge = 1;
        check("txlow_at4", 32'(tx_low_o), 1);
      end
      if (level_o == 5) check("txlow_at5", 32'(tx_low_o), 0);
      prev_lvl = level_o;
    end
    check("drain_count", 32'(nsent), 16);
    check("txlow_edge_seen", 32'(low_edge), 1);
    for (int c = 0; c < 12; c++) begin tx_data_ready_i = (busy == 0); tick(); if (busy > 0) busy--; end

    // flush while a byte is in flight
    tx_en_i = 0; tx_data_ready_i = 0;
    for (int i = 0; i < 6; i++) begin wr_en_i = 1; wr_data_i = 8'h40 + 8'(i); tick(); end
    wr_en_i = 0; tx_en_i = 1; tx_data_ready_i = 1; tick();
    check("fl_send", 32'(send_o), 1);
    check("fl_txd", 32'(tx_data_o), 8'h40);
    check("fl_level5", 32'(level_o), 5);
    tick();
    flush_i = 1; tick();
    check("fl_level0", 32'(level_o), 0);
    check("fl_empty", 32'(empty_o), 1);
    flush_i = 0; tx_data_ready_i = 0; tick();
    check("fl_inflight_txd", 32'(tx_data_o), 8'h40);
    tx_data_ready_i = 1; nsent = 0;
    for (int c = 0; c < 10; c++) begin tick(); if (send_o) nsent++; end
    check("fl_no_more_send", 32'(nsent), 0);

    // async reset in the wait-for-accept phase
    tx_en_i = 0; tx_data_ready_i = 0;
    for (int i = 0; i < 3; i++) begin wr_en_i = 1; wr_data_i = 8'h70 + 8'(i); tick(); end
    wr_en_i = 0; tx_en_i = 1; tx_data_ready_i = 1; tick();
    check("ar_send", 32'(send_o), 1);
    tick();
    rst_i = 1; #1;
    check("ar_send0", 32'(send_o), 0);
    check("ar_level0", 32'(level_o), 0);
    check("ar_empty", 32'(empty_o), 1);
    check("ar_txd0", 32'(tx_data_o), 0);
    tick();
    rst_i = 0;
    wr_en_i = 1; wr_data_i = 8'h5A; tick();
    wr_en_i = 0; tick();
    check("ar_idle_send", 32'(send_o), 1);
    check("ar_idle_txd", 32'(tx_data_o), 8'h5A);

    // randomized traffic against the model
    busy = 0;
    for (int c = 0; c < 2000; c++) begin
      wr_en_i   = ($urandom_range(0, 99) < 55);
      wr_data_i = 8'($urandom);
      flush_i   = ($urandom_range(0, 99) < 3);
      tx_en_i   = ($urandom_range(0, 99) < 85);
      ovf_clr_i = ($urandom_range(0, 99) < 6);
      tx_data_ready_i = (busy == 0);
      tick();
      if (busy > 0) busy--;
      if (send_o) busy = $urandom_range(1, 6);
    end
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
